stopwatch_display_mux: RTL

- Downstream consumer of the stopwatch minute and second counters.
- Converts the 6-bit binary minute and second counts to BCD and drives a 4-digit, time-multiplexed, common-anode 7-segment display in MM.SS form.
- The decimal point of the minutes-ones digit acts as the separator: it blinks while the stopwatch runs and is steady when stopped.
- Inputs are snapshotted once per scan frame, so a frame never shows a mix of old and new digits.

---
 rtl/stopwatch_display_mux.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_display_mux.sv
// Scans the stopwatch minute/second counts onto a 4-digit common-anode 7-segment
// display as MM.SS, with a blinking separator and per-frame input snapshots.
module stopwatch_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 125,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] min_count,
  input  logic [5:0] sec_count,
  input  logic       running,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  // Binary 0..59 to {tens, ones} by restoring subtraction; out-of-range shows dashes.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    if (v >= 6'd60) return {CODE_DASH, CODE_DASH};
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    return {t, 4'(r)};
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:       return 7'h40;
      4'd1:       return 7'h79;
      4'd2:       return 7'h24;
      4'd3:       return 7'h30;
      4'd4:       return 7'h19;
      4'd5:       return 7'h12;
      4'd6:       return 7'h02;
      4'd7:       return 7'h78;
      4'd8:       return 7'h00;
      4'd9:       return 7'h10;
      CODE_DASH:  return 7'h3F;
      default:    return 7'h7F;
    endcase
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    d_q, d_d;
  logic [5:0]    min_snap_q, min_snap_d;
  logic [5:0]    sec_snap_q, sec_snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       slot_end, frame_end;
  logic [7:0] min_bcd, sec_bcd;
  logic [3:0] digit_code;

  assign slot_end  = (pre_q == PRE_LAST);
  assign frame_end = slot_end && (d_q == 2'd3);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pre_d       = pre_q + 1'b1;
    d_d         = d_q;
    min_snap_d  = min_snap_q;
    sec_snap_d  = sec_snap_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (slot_end) begin
      pre_d = '0;
      d_d   = d_q + 2'd1;
    end

    // Snapshots only move at the frame boundary, so one frame never mixes old and new digits.
    if (frame_end) begin
      min_snap_d = min_count;
      sec_snap_d = sec_count;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    min_bcd    = to_bcd(min_snap_q);
    sec_bcd    = to_bcd(sec_snap_q);
    digit_code = CODE_BLANK;
    case (d_q)
      2'd0: digit_code = sec_bcd[3:0];
      2'd1: digit_code = sec_bcd[7:4];
      2'd2: digit_code = min_bcd[3:0];
      2'd3: digit_code = (LZ_BLANK && (min_bcd[7:4] == 4'd0)) ? CODE_BLANK : min_bcd[7:4];
      default: digit_code = CODE_BLANK;
    endcase

    an_d  = (pre_q < BLANK_END) ? 4'b1111 : ~(4'b0001 << d_q);
    seg_d = seg_pattern(digit_code);
    // running is used live so the separator reacts within one cycle.
    dp_d  = ~((d_q == 2'd2) && (pre_q >= BLANK_END) && (!running || blink_ph_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q       <= '0;
      d_q         <= 2'd0;
      min_snap_q  <= 6'd0;
      sec_snap_q  <= 6'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pre_q       <= pre_d;
      d_q         <= d_d;
      min_snap_q  <= min_snap_d;
      sec_snap_q  <= sec_snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
